logic_engine: RTL
=================

LOGIC_ENGINE -- requirements
Module: logic_engine

Interface
REQ-001 Parameter WIDTH, default 4, operand width; SHALL be a power of two, >= 2.
REQ-002 Parameter CW, default $clog2(WIDTH), rotate-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 x  input  WIDTH  operand A.
REQ-006 y  input  WIDTH  operand B.
REQ-007 op  input  3  operation select.
REQ-008 acc_en  input  1  substitute the accumulator for x and write the result back.
REQ-009 in_valid  input  1  request present.
REQ-010 in_ready  output  1  engine can accept a request.
REQ-011 z  output  2*WIDTH  result.
REQ-012 out_valid  output  1  z holds a completed result.
REQ-013 out_ready  input  1  consumer takes z.
REQ-014 acc  output  WIDTH  accumulator contents.

Function
REQ-015 Op encoding:
- 0 AND, 1 OR, 2 XOR, 4 NAND, 5 XNOR: bitwise on A and y.
- 3 NOT: ~{y,A}.
- 6 ROTL: rotate A left by y[CW-1:0].
- 7 POPCOUNT: number of ones in {y,A}.
REQ-016 A SHALL be x when acc_en=0 at accept, and acc when acc_en=1.
REQ-017 Every result except NOT SHALL be zero-extended to 2*WIDTH bits; NOT SHALL fill all 2*WIDTH bits.
REQ-018 Accept SHALL occur on an edge with in_valid && in_ready; x, y, op and acc_en SHALL be captured at that edge and ignored afterwards.
REQ-019 FSM states SHALL be IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 IDLE transitions: on accept of ops 0-5, or ROTL with amount 0, go to DONE with z computed; otherwise go to EXEC.
REQ-021 ROTL in EXEC: rotate one bit per cycle for amount cycles, then go to DONE; out_valid SHALL rise amount+1 cycles after the accept edge.
REQ-022 POPCOUNT in EXEC: examine one bit per cycle, LSB first, for 2*WIDTH cycles, then go to DONE; out_valid SHALL rise 2*WIDTH+1 cycles after accept.
REQ-023 Single-cycle ops SHALL assert out_valid on the cycle after accept (latency 1).
REQ-024 DONE: z SHALL stay stable while out_valid && !out_ready; when out_ready=1, go to IDLE on the next edge.
REQ-025 in_ready and out_valid SHALL never both be 1; throughput is one result per 2 cycles at best.
REQ-026 When acc_en was captured as 1, acc SHALL load z[WIDTH-1:0] on the edge entering DONE; otherwise acc SHALL be unchanged.
REQ-027 in_valid while busy SHALL be ignored, and no request SHALL be queued.
REQ-028 Internal counters SHALL be sized to reach 2*WIDTH without wrap.

Reset
REQ-029 While rst=1 at an edge:
- state SHALL become IDLE.
- z, acc and out_valid SHALL become 0.
- in_ready SHALL become 1 on the following cycle.
REQ-030 rst SHALL take priority over accept, EXEC progress and the DONE handshake; an in-flight operation SHALL be discarded without touching acc.
REQ-031 In-flight and outputs SHALL never be X after the first reset edge.

Verification (WIDTH=4)
REQ-032 op=0, x=4'b1100, y=4'b1010, out_ready=1 -> z=8'h08, out_valid one cycle after accept, in_ready back the next cycle.
REQ-033 op=3, x=4'h3, y=4'h5 -> z=8'hAC, latency 1.
REQ-034 op=6, x=4'b1001, y=4'd3 -> z=8'h0C, out_valid 4 cycles after accept; with y=4'd4 (amount 0) -> z=8'h09, latency 1.
REQ-035 op=7, x=4'hF, y=4'h1 -> z=8'h05, out_valid 9 cycles after accept.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands -> z stable, in_ready=0, the new request is not accepted until the cycle after out_ready=1.
REQ-037 Accumulate and reset:
- acc=0, then op=1, acc_en=1, y=4'h5 -> acc=4'h5.
- Then op=2, acc_en=1, y=4'hF -> acc=4'hA.
- Then rst mid-POPCOUNT -> acc=0, z=0, out_valid=0, and no result is emitted.

Source files
------------

// File: rtl/logic_engine.sv
// logic_engine: bitwise / rotate / popcount engine with an optional accumulator
// operand. Single-cycle ops finish straight from IDLE. ROTL rotates one bit per
// cycle. POPCOUNT examines one bit per cycle. Each result is held in DONE until
// the consumer takes it.
module logic_engine #(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic [2:0]           op,
   input  logic                 acc_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     acc
);

   localparam int ZW   = 2 * WIDTH;
   localparam int CNTW = $clog2(ZW) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NOT  = 3'd3,
      OP_NAND = 3'd4,
      OP_XNOR = 3'd5,
      OP_ROTL = 3'd6,
      OP_POP  = 3'd7
   } op_e;

   state_e            state;
   logic              pop_mode;
   logic              acc_en_q;
   logic [WIDTH-1:0]  rot;
   logic [ZW-1:0]     sh;
   logic [CNTW-1:0]   cnt;
   logic [CNTW-1:0]   pop;

   logic [WIDTH-1:0]  a_sel;
   logic [CW-1:0]     amt;
   logic [ZW-1:0]     quick;
   logic              go_exec;
   logic [WIDTH-1:0]  rot_nx;
   logic [CNTW-1:0]   pop_nx;
   logic [ZW-1:0]     pop_z;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Operand selection, single-cycle results and next values for the iterative ops
   always_comb begin
      a_sel   = acc_en ? acc : x;
      amt     = y[CW-1:0];
      quick   = '0;
      case (op)
         OP_AND:  quick[WIDTH-1:0] = a_sel & y;
         OP_OR:   quick[WIDTH-1:0] = a_sel | y;
         OP_XOR:  quick[WIDTH-1:0] = a_sel ^ y;
         OP_NOT:  quick            = ~{y, a_sel};
         OP_NAND: quick[WIDTH-1:0] = ~(a_sel & y);
         OP_XNOR: quick[WIDTH-1:0] = ~(a_sel ^ y);
         OP_ROTL: quick[WIDTH-1:0] = a_sel;
         default: quick            = '0;
      endcase
      go_exec = (op == OP_POP) || ((op == OP_ROTL) && (amt != '0));
      rot_nx  = {rot[WIDTH-2:0], rot[WIDTH-1]};
      pop_nx  = pop + CNTW'(sh[0]);
      pop_z   = ZW'(pop_nx);
   end

   // Control FSM plus result, accumulator and iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pop_mode <= 1'b0;
         acc_en_q <= 1'b0;
         rot      <= '0;
         sh       <= '0;
         cnt      <= '0;
         pop      <= '0;
         z        <= '0;
         acc      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc_en_q <= acc_en;
                  if (go_exec) begin
                     state    <= EXEC;
                     pop_mode <= (op == OP_POP);
                     rot      <= a_sel;
                     sh       <= {y, a_sel};
                     pop      <= '0;
                     cnt      <= (op == OP_POP) ? CNTW'(ZW) : CNTW'(amt);
                  end else begin
                     state <= DONE;
                     z     <= quick;
                     if (acc_en)
                        acc <= quick[WIDTH-1:0];
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - CNTW'(1);
               if (pop_mode) begin
                  pop <= pop_nx;
                  sh  <= sh >> 1;
               end else begin
                  rot <= rot_nx;
               end
               // The last iteration writes its result straight into z, so DONE
               // is entered on the same edge as the final step.
               if (cnt == CNTW'(1)) begin
                  state <= DONE;
                  if (pop_mode) begin
                     z <= pop_z;
                     if (acc_en_q)
                        acc <= pop_z[WIDTH-1:0];
                  end else begin
                     z <= ZW'(rot_nx);
                     if (acc_en_q)
                        acc <= rot_nx;
                  end
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
